// File: rtl/unidade_forwarding_n_if.sv
// Bundle of operand, bypass and hazard signals between the ID/EX stage logic and
// the forwarding unit. The pipeline side uses master and the forwarding unit uses slave.
interface unidade_forwarding_n_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int CNT_W      = 16
);
  logic                          enable;
  logic                          clr_cnt;
  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr;
  logic [NUM_SRC*DATA_W-1:0]     src_data;
  logic [REG_ADDR_W-1:0]         exmem_rd;
  logic                          exmem_we;
  logic [DATA_W-1:0]             exmem_data;
  logic [REG_ADDR_W-1:0]         memwb_rd;
  logic                          memwb_we;
  logic [DATA_W-1:0]             memwb_data;
  logic [REG_ADDR_W-1:0]         idex_rd;
  logic                          idex_is_load;
  logic [NUM_SRC*DATA_W-1:0]     operand;
  logic [NUM_SRC*2-1:0]          fwd_sel;
  logic                          valid_out;
  logic                          stall;
  logic [CNT_W-1:0]              cnt_fwd;
  logic [CNT_W-1:0]              cnt_stall;

  modport master (
    output enable, clr_cnt, src_addr, src_data,
           exmem_rd, exmem_we, exmem_data,
           memwb_rd, memwb_we, memwb_data,
           idex_rd, idex_is_load,
    input  operand, fwd_sel, valid_out, stall, cnt_fwd, cnt_stall
  );

  modport slave (
    input  enable, clr_cnt, src_addr, src_data,
           exmem_rd, exmem_we, exmem_data,
           memwb_rd, memwb_we, memwb_data,
           idex_rd, idex_is_load,
    output operand, fwd_sel, valid_out, stall, cnt_fwd, cnt_stall
  );
endinterface

// File: rtl/unidade_forwarding_n.sv
// EX-stage forwarding and load-use hazard unit: picks each operand from the register
// file, EX/MEM or MEM/WB, registers it at ID/EX and counts forward/stall activity.
module unidade_forwarding_n #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int CNT_W      = 16
) (
  input logic                  clock,
  input logic                  reset_n,
  unidade_forwarding_n_if.slave bus
);

  localparam int SUM_W = CNT_W + $clog2(NUM_SRC + 1);
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [NUM_SRC*DATA_W-1:0] operand_sel, operand_d, operand_q;
  logic [NUM_SRC*2-1:0]      sel_cur, sel_d, sel_q;
  logic                      valid_d, valid_q;
  logic [CNT_W-1:0]          cnt_fwd_d, cnt_fwd_q;
  logic [CNT_W-1:0]          cnt_stall_d, cnt_stall_q;
  logic [SUM_W-1:0]          fwd_num, fwd_sum, stall_sum;
  logic                      stall;

  // EX/MEM is checked first so the younger result wins; register 0 never forwards.
  always_comb begin
    operand_sel = '0;
    sel_cur     = '0;
    fwd_num     = '0;
    stall       = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.exmem_we && (bus.exmem_rd != '0) &&
          (bus.exmem_rd == bus.src_addr[i*REG_ADDR_W +: REG_ADDR_W])) begin
        sel_cur[i*2 +: 2]              = 2'b10;
        operand_sel[i*DATA_W +: DATA_W] = bus.exmem_data;
        fwd_num                         = fwd_num + SUM_W'(1);
      end else if (bus.memwb_we && (bus.memwb_rd != '0) &&
                   (bus.memwb_rd == bus.src_addr[i*REG_ADDR_W +: REG_ADDR_W])) begin
        sel_cur[i*2 +: 2]              = 2'b01;
        operand_sel[i*DATA_W +: DATA_W] = bus.memwb_data;
        fwd_num                         = fwd_num + SUM_W'(1);
      end else begin
        sel_cur[i*2 +: 2]              = 2'b00;
        operand_sel[i*DATA_W +: DATA_W] = bus.src_data[i*DATA_W +: DATA_W];
      end
      if (bus.idex_is_load && (bus.idex_rd != '0) &&
          (bus.idex_rd == bus.src_addr[i*REG_ADDR_W +: REG_ADDR_W])) begin
        stall = 1'b1;
      end
    end
  end

  always_comb begin
    fwd_sum     = SUM_W'(cnt_fwd_q) + fwd_num;
    stall_sum   = SUM_W'(cnt_stall_q) + SUM_W'(1);
    operand_d   = operand_q;
    sel_d       = sel_q;
    valid_d     = valid_q;
    cnt_fwd_d   = cnt_fwd_q;
    cnt_stall_d = cnt_stall_q;
    if (bus.enable) begin
      // A stall freezes the operands and sends a bubble into EX instead.
      if (stall) begin
        valid_d     = 1'b0;
        cnt_stall_d = (stall_sum > CNT_MAX) ? {CNT_W{1'b1}} : stall_sum[CNT_W-1:0];
      end else begin
        operand_d = operand_sel;
        sel_d     = sel_cur;
        valid_d   = 1'b1;
        cnt_fwd_d = (fwd_sum > CNT_MAX) ? {CNT_W{1'b1}} : fwd_sum[CNT_W-1:0];
      end
    end
    if (bus.clr_cnt) begin
      cnt_fwd_d   = '0;
      cnt_stall_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      operand_q   <= '0;
      sel_q       <= '0;
      valid_q     <= 1'b0;
      cnt_fwd_q   <= '0;
      cnt_stall_q <= '0;
    end else begin
      operand_q   <= operand_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      cnt_fwd_q   <= cnt_fwd_d;
      cnt_stall_q <= cnt_stall_d;
    end
  end

  assign bus.operand   = operand_q;
  assign bus.fwd_sel   = sel_q;
  assign bus.valid_out = valid_q;
  assign bus.stall     = stall;
  assign bus.cnt_fwd   = cnt_fwd_q;
  assign bus.cnt_stall = cnt_stall_q;

endmodule

// File: tb/tb_unidade_forwarding_n.sv
// Directed bench for the forwarding unit; a 4-bit counter build makes saturation
// reachable in a few cycles.
module tb_unidade_forwarding_n;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_SRC    = 2;
  localparam int CNT_W      = 4;

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  unidade_forwarding_n_if #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)
  ) bus_if ();

  unidade_forwarding_n #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_idle();
    bus_if.enable       = 1'b1;
    bus_if.clr_cnt      = 1'b0;
    bus_if.exmem_we     = 1'b0;
    bus_if.exmem_rd     = '0;
    bus_if.exmem_data   = '0;
    bus_if.memwb_we     = 1'b0;
    bus_if.memwb_rd     = '0;
    bus_if.memwb_data   = '0;
    bus_if.idex_is_load = 1'b0;
    bus_if.idex_rd      = '0;
  endtask

  task automatic clock_edge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clock   = 1'b0;
    reset_n = 1'b0;
    apply_idle();
    bus_if.src_addr     = {5'd7, 5'd4};
    bus_if.src_data     = {32'($urandom()), 32'($urandom())};
    bus_if.exmem_we     = 1'b1;
    bus_if.exmem_rd     = 5'd7;
    bus_if.exmem_data   = 32'($urandom());
    bus_if.memwb_we     = 1'b1;
    bus_if.memwb_rd     = 5'd4;
    bus_if.memwb_data   = 32'($urandom());
    bus_if.idex_is_load = 1'b1;
    bus_if.idex_rd      = 5'd4;

    // Reset held across several edges with busy inputs
    repeat (3) @(posedge clock);
    #1;
    check_output("rst_operand", 64'(bus_if.operand), 64'h0);
    check_output("rst_fwd_sel", 64'(bus_if.fwd_sel), 64'h0);
    check_output("rst_valid", 64'(bus_if.valid_out), 64'h0);
    check_output("rst_cnt_fwd", 64'(bus_if.cnt_fwd), 64'h0);
    check_output("rst_cnt_stall", 64'(bus_if.cnt_stall), 64'h0);
    check_output("rst_stall_on", 64'(bus_if.stall), 64'h1);
    bus_if.idex_is_load = 1'b0;
    #1;
    check_output("rst_stall_off", 64'(bus_if.stall), 64'h0);

    // First instruction after reset, no bypass
    @(negedge clock);
    reset_n = 1'b1;
    apply_idle();
    bus_if.src_addr = {5'd2, 5'd1};
    bus_if.src_data = {32'hB, 32'hA};
    clock_edge();
    check_output("plain_operand", 64'(bus_if.operand), {32'hB, 32'hA});
    check_output("plain_sel", 64'(bus_if.fwd_sel), 64'h0);
    check_output("plain_valid", 64'(bus_if.valid_out), 64'h1);
    check_output("plain_cnt_fwd", 64'(bus_if.cnt_fwd), 64'h0);

    // EX/MEM and MEM/WB both match r3: EX/MEM wins
    @(negedge clock);
    bus_if.src_addr   = {5'd2, 5'd3};
    bus_if.exmem_we   = 1'b1;
    bus_if.exmem_rd   = 5'd3;
    bus_if.exmem_data = 32'h11;
    bus_if.memwb_we   = 1'b1;
    bus_if.memwb_rd   = 5'd3;
    bus_if.memwb_data = 32'h22;
    clock_edge();
    check_output("prio_operand", 64'(bus_if.operand), {32'hB, 32'h11});
    check_output("prio_sel", 64'(bus_if.fwd_sel), 64'b0010);
    check_output("prio_cnt_fwd", 64'(bus_if.cnt_fwd), 64'd1);

    @(negedge clock);
    bus_if.exmem_we = 1'b0;
    clock_edge();
    check_output("memwb_operand", 64'(bus_if.operand), {32'hB, 32'h22});
    check_output("memwb_sel", 64'(bus_if.fwd_sel), 64'b0001);
    check_output("memwb_cnt_fwd", 64'(bus_if.cnt_fwd), 64'd2);

    // Register 0 is never forwarded
    @(negedge clock);
    apply_idle();
    bus_if.src_addr   = {5'd2, 5'd0};
    bus_if.exmem_we   = 1'b1;
    bus_if.exmem_rd   = 5'd0;
    bus_if.exmem_data = 32'h33;
    clock_edge();
    check_output("r0_operand", 64'(bus_if.operand), {32'hB, 32'hA});
    check_output("r0_sel", 64'(bus_if.fwd_sel), 64'h0);
    check_output("r0_cnt_fwd", 64'(bus_if.cnt_fwd), 64'd2);

    // Both operands from EX/MEM
    @(negedge clock);
    bus_if.src_addr   = {5'd6, 5'd6};
    bus_if.exmem_rd   = 5'd6;
    bus_if.exmem_data = 32'h44;
    clock_edge();
    check_output("both_operand", 64'(bus_if.operand), {32'h44, 32'h44});
    check_output("both_sel", 64'(bus_if.fwd_sel), 64'b1010);
    check_output("both_cnt_fwd", 64'(bus_if.cnt_fwd), 64'd4);

    // Operand 0 from EX/MEM, operand 1 from MEM/WB
    @(negedge clock);
    bus_if.src_addr   = {5'd9, 5'd8};
    bus_if.exmem_rd   = 5'd8;
    bus_if.exmem_data = 32'h55;
    bus_if.memwb_we   = 1'b1;
    bus_if.memwb_rd   = 5'd9;
    bus_if.memwb_data = 32'h66;
    clock_edge();
    check_output("mixed_operand", 64'(bus_if.operand), {32'h66, 32'h55});
    check_output("mixed_sel", 64'(bus_if.fwd_sel), 64'b0110);
    check_output("mixed_cnt_fwd", 64'(bus_if.cnt_fwd), 64'd6);

    // Load into r0 never stalls; load into r5 with r5 consumer stalls at once
    @(negedge clock);
    apply_idle();
    bus_if.src_addr     = {5'd5, 5'd0};
    bus_if.src_data     = {32'hC, 32'hD};
    bus_if.idex_is_load = 1'b1;
    bus_if.idex_rd      = 5'd0;
    #1;
    check_output("load_r0_stall", 64'(bus_if.stall), 64'h0);
    bus_if.src_addr   = {5'd5, 5'd4};
    bus_if.idex_rd    = 5'd5;
    bus_if.exmem_we   = 1'b1;
    bus_if.exmem_rd   = 5'd4;
    bus_if.exmem_data = 32'h77;
    #1;
    check_output("load_use_stall", 64'(bus_if.stall), 64'h1);
    clock_edge();
    check_output("bubble_valid", 64'(bus_if.valid_out), 64'h0);
    check_output("bubble_operand", 64'(bus_if.operand), {32'h66, 32'h55});
    check_output("bubble_sel", 64'(bus_if.fwd_sel), 64'b0110);
    check_output("bubble_cnt_stall", 64'(bus_if.cnt_stall), 64'd1);
    check_output("bubble_cnt_fwd", 64'(bus_if.cnt_fwd), 64'd6);

    // Load has moved on: stall drops, instruction issues
    @(negedge clock);
    bus_if.idex_is_load = 1'b0;
    #1;
    check_output("after_load_stall", 64'(bus_if.stall), 64'h0);
    clock_edge();
    check_output("resume_valid", 64'(bus_if.valid_out), 64'h1);
    check_output("resume_operand", 64'(bus_if.operand), {32'hC, 32'h77});
    check_output("resume_sel", 64'(bus_if.fwd_sel), 64'b0010);
    check_output("resume_cnt_fwd", 64'(bus_if.cnt_fwd), 64'd7);
    check_output("resume_cnt_stall", 64'(bus_if.cnt_stall), 64'd1);

    // enable=0 freezes registers and counters while stall still reacts
    @(negedge clock);
    bus_if.enable       = 1'b0;
    bus_if.idex_is_load = 1'b1;
    bus_if.idex_rd      = 5'd4;
    #1;
    check_output("hold_stall", 64'(bus_if.stall), 64'h1);
    clock_edge();
    check_output("hold_valid", 64'(bus_if.valid_out), 64'h1);
    check_output("hold_cnt_stall", 64'(bus_if.cnt_stall), 64'd1);
    @(negedge clock);
    bus_if.idex_is_load = 1'b0;
    bus_if.exmem_data   = 32'h88;
    clock_edge();
    check_output("hold_operand", 64'(bus_if.operand), {32'hC, 32'h77});
    check_output("hold_cnt_fwd", 64'(bus_if.cnt_fwd), 64'd7);

    // Clear beats a same-cycle forward increment
    @(negedge clock);
    bus_if.enable     = 1'b1;
    bus_if.clr_cnt    = 1'b1;
    bus_if.exmem_data = 32'h99;
    clock_edge();
    check_output("clr_cnt_fwd", 64'(bus_if.cnt_fwd), 64'd0);
    check_output("clr_cnt_stall", 64'(bus_if.cnt_stall), 64'd0);
    check_output("clr_operand", 64'(bus_if.operand), {32'hC, 32'h99});

    // Forward both operands every cycle: +2 per edge, clamps at 15
    @(negedge clock);
    bus_if.clr_cnt  = 1'b0;
    bus_if.src_addr = {5'd4, 5'd4};
    for (int k = 0; k < 20; k++) begin
      clock_edge();
      check_output("sat_cnt_fwd", 64'(bus_if.cnt_fwd), (2 * (k + 1) > 15) ? 64'd15 : 64'(2 * (k + 1)));
    end

    // Stall every cycle: +1 per edge, clamps at 15
    @(negedge clock);
    bus_if.idex_is_load = 1'b1;
    bus_if.idex_rd      = 5'd4;
    for (int k = 0; k < 20; k++) begin
      clock_edge();
      check_output("sat_cnt_stall", 64'(bus_if.cnt_stall), (k + 1 > 15) ? 64'd15 : 64'(k + 1));
    end
    check_output("sat_fwd_kept", 64'(bus_if.cnt_fwd), 64'd15);

    // Asynchronous reset in mid-stall clears everything without an edge
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_operand", 64'(bus_if.operand), 64'h0);
    check_output("async_sel", 64'(bus_if.fwd_sel), 64'h0);
    check_output("async_valid", 64'(bus_if.valid_out), 64'h0);
    check_output("async_cnt_fwd", 64'(bus_if.cnt_fwd), 64'h0);
    check_output("async_cnt_stall", 64'(bus_if.cnt_stall), 64'h0);

    @(negedge clock);
    reset_n = 1'b1;
    apply_idle();
    bus_if.src_addr   = {5'd2, 5'd1};
    bus_if.src_data   = {32'hB, 32'hA};
    bus_if.exmem_we   = 1'b1;
    bus_if.exmem_rd   = 5'd1;
    bus_if.exmem_data = 32'h5A;
    clock_edge();
    check_output("post_rst_operand", 64'(bus_if.operand), {32'hB, 32'h5A});
    check_output("post_rst_cnt_fwd", 64'(bus_if.cnt_fwd), 64'd1);
    check_output("post_rst_cnt_stall", 64'(bus_if.cnt_stall), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidade_forwarding_n.md
# unidade_forwarding_n

Parametrised forwarding and load-use hazard unit for the EX stage of the pipelined processor. For each of NUM_SRC source operands, it selects between the register-file value, the EX/MEM ALU result and the MEM/WB write-back value. It also detects load-use hazards and asserts a stall. The selected operands, the select codes and a valid flag are registered at the ID/EX boundary, and two saturating counters track forwarding and stall activity.

## Interface
Parameters:
- DATA_W, 32, operand/data width
- REG_ADDR_W, 5, register index width
- NUM_SRC, 2, number of source operands handled (≥1)
- CNT_W, 16, statistics counter width

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  pipeline advance; 0 = hold all registers
- clr_cnt  in  1  synchronous clear of both counters
- src_addr  in  NUM_SRC*REG_ADDR_W  source register indices, operand i at bits [i*REG_ADDR_W +: REG_ADDR_W]
- src_data  in  NUM_SRC*DATA_W  register-file read data, same packing
- exmem_rd  in  REG_ADDR_W  destination register of EX/MEM instruction
- exmem_we  in  1  EX/MEM writes a register
- exmem_data  in  DATA_W  EX/MEM ALU result
- memwb_rd  in  REG_ADDR_W  destination register of MEM/WB instruction
- memwb_we  in  1  MEM/WB writes a register
- memwb_data  in  DATA_W  write-back mux result
- idex_rd  in  REG_ADDR_W  destination register of the instruction currently in EX
- idex_is_load  in  1  instruction in EX is a load
- operand  out  NUM_SRC*DATA_W  registered selected operands
- fwd_sel  out  NUM_SRC*2  registered select per operand: 00 register file, 10 EX/MEM, 01 MEM/WB
- valid_out  out  1  registered; 1 = operand holds a real instruction, 0 = bubble
- stall  out  1  combinational load-use stall request
- cnt_fwd  out  CNT_W  saturating count of forwarded operands
- cnt_stall  out  CNT_W  saturating count of stall cycles

## Operation
Per-operand selection is combinational and is evaluated independently for each operand i:
- If exmem_we=1, exmem_rd≠0 and exmem_rd==src_addr[i], then sel=10 and the value is exmem_data.
- Otherwise, if memwb_we=1, memwb_rd≠0 and memwb_rd==src_addr[i], then sel=01 and the value is memwb_data.
- Otherwise sel=00 and the value is src_data[i].
- When both EX/MEM and MEM/WB match, EX/MEM wins.
- Register 0 is never forwarded.

Hazard detection:
- stall = idex_is_load & (idex_rd≠0) & (idex_rd equals any src_addr[i]).

Register update, on each rising edge with enable=1:
- If stall=0: operand and fwd_sel load the selected values, and valid_out=1.
- If stall=1: operand and fwd_sel hold their values, and valid_out=0 (a bubble is injected into EX).
- If enable=0: operand, fwd_sel, valid_out and both counters all hold. The stall output is still driven combinationally.

Counters:
- cnt_fwd increases by the number of operands with sel≠00, on edges where enable=1 and stall=0.
- cnt_stall increases by 1 on edges where enable=1 and stall=1.
- Both counters saturate at 2^CNT_W−1. An increment that would overflow clamps to all-ones.
- clr_cnt=1 forces both counters to 0 on the next edge and takes priority over any same-cycle increment.

## Timing
- Asynchronous reset: when reset_n=0, operand, fwd_sel, valid_out, cnt_fwd and cnt_stall go to 0 immediately. Registers resume on the first rising edge after reset_n returns to 1.
- Reset asserted in the middle of a stall or a forward discards the in-flight result; no partial counts are kept.
- Operand latency: one cycle. Inputs sampled at edge k appear on operand and fwd_sel after edge k.
- stall has zero latency. It is purely combinational from the current-cycle inputs, so the upstream stage can freeze in the same cycle.
- A load-use pair yields exactly one stall cycle. On the following cycle the load is in EX/MEM (idex_is_load drops) and its data is forwarded from MEM/WB or EX/MEM, as the surrounding pipeline presents it.

## Test plan
- Reset: hold reset_n=0 with random inputs; all outputs are 0 and stall follows its inputs. Release reset, apply src_addr={2,1}, src_data={0xB,0xA}, no writes → after 1 edge operand={0xB,0xA}, fwd_sel={00,00}, valid_out=1.
- Priority: exmem_rd=memwb_rd=3, both we=1, exmem_data=0x11, memwb_data=0x22, src_addr[0]=3 → operand[0]=0x11, fwd_sel[0]=10, cnt_fwd +1. Set exmem_we=0 → operand[0]=0x22, fwd_sel[0]=01.
- Register 0: src_addr[0]=0, exmem_rd=0, exmem_we=1 → fwd_sel[0]=00 and operand[0]=src_data[0]. Both operands matching EX/MEM → cnt_fwd +2.
- Load-use: idex_is_load=1, idex_rd=5, src_addr[1]=5 → stall=1 immediately. After the edge, valid_out=0, operand holds and cnt_stall=1. Set idex_is_load=0 → stall=0 and valid_out=1 on the next edge.
- Hold/clear: enable=0 with a stall present → stall=1, but no register or counter changes. clr_cnt=1 with a forward in the same cycle → both counters become 0.
- Saturation: CNT_W=4, run 20 forwarding cycles → cnt_fwd stops at 15 and never wraps.
